// File: rtl/rx_uart_ext.sv
// Parametrised UART receiver: 2-FF input synchroniser, false-start rejection, framing
// check, NB_STOP stop bits. Optional parity bit is compiled in with UART_RX_PARITY_EN.
module rx_uart_ext #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int NB_STOP = 1
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  input  logic            i_parity_odd,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_data,
  output logic            o_frame_err,
  output logic            o_parity_err,
  output logic            o_busy
);
  localparam int TW = $clog2(SB_TICK);
  localparam int BW = $clog2(DBIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(SB_TICK / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DBIT - 1);
  localparam logic          STOP_LAST = 1'(NB_STOP - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            stop_cnt;
  logic [DBIT-1:0] shift;
  logic            frame_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = i_parity_odd;
  assign o_parity_err      = 1'b0;
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      state          <= IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      shift          <= '0;
      frame_bad      <= 1'b0;
      o_rx_done_tick <= 1'b0;
      o_data         <= '0;
      o_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad        <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      rx_meta        <= i_rx;
      rx_s           <= rx_meta;
      o_rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          // Leaves IDLE on the synchronised low level alone; ticks are ignored here.
          if (!rx_s) begin
            state     <= START;
            tick_cnt  <= '0;
            frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
          end
        end
        START: if (i_s_tick) begin
          if (tick_cnt == HALF_LAST) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: if (i_s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[DBIT-1:1]};
            if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
              state    <= PARITY;
`else
              state    <= STOP;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (i_s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            par_bad  <= ((^shift) ^ rx_s) != i_parity_odd;
            tick_cnt <= '0;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
`endif
        STOP: if (i_s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt <= '0;
            // The last stop sample is folded straight into the delivered flag.
            if (stop_cnt == STOP_LAST) begin
              o_rx_done_tick <= 1'b1;
              o_data         <= shift;
              o_frame_err    <= frame_bad | ~rx_s;
`ifdef UART_RX_PARITY_EN
              o_parity_err   <= par_bad;
`endif
              state          <= IDLE;
            end else begin
              frame_bad <= frame_bad | ~rx_s;
              stop_cnt  <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_uart_ext.sv
// Bench for rx_uart_ext: lane 0 is an 8-bit/1-stop receiver, lane 1 a 9-bit/2-stop one.
// Frames are built bit by bit from their content; expectations come from that content.
module tb_rx_uart_ext;
  localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       parity_odd = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       done0, ferr0, perr0, busy0;
  logic [7:0] data0;
  logic       done1, ferr1, perr1, busy1;
  logic [8:0] data1;

  int          tick_div = 4;
  int          n_cmp = 0, n_bad = 0;
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] last0 = '0, last1 = '0;
  bit          rst_d = 1'b0, armed = 1'b0;

  rx_uart_ext #(.DBIT(8), .SB_TICK(SB_TICK), .NB_STOP(1)) u_dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx(rx0), .i_s_tick(s_tick),
    .i_parity_odd(parity_odd), .o_rx_done_tick(done0), .o_data(data0),
    .o_frame_err(ferr0), .o_parity_err(perr0), .o_busy(busy0)
  );

  rx_uart_ext #(.DBIT(9), .SB_TICK(SB_TICK), .NB_STOP(2)) u_dut9 (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx(rx1), .i_s_tick(s_tick),
    .i_parity_odd(parity_odd), .o_rx_done_tick(done1), .o_data(data1),
    .o_frame_err(ferr1), .o_parity_err(perr1), .o_busy(busy1)
  );

  // Clock and oversampling strobe (one pulse every tick_div clocks).
  always #5 i_clock = ~i_clock;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge i_clock);
      #1;
      c = (c + 1) % tick_div;
      s_tick = (c == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one queue entry {perr, ferr, data} per frame; held values between pulses.
  task automatic check_lane(input int lane, input logic done, input logic busy,
                            input logic [8:0] data, input logic ferr, input logic perr);
    logic [10:0] got, e, last;
    got  = {perr, ferr, data};
    last = (lane == 0) ? last0 : last1;
    if (rst_d) begin
      chk($sformatf("reset_outputs_lane%0d", lane), {done, busy, got}, 32'd0);
      armed = 1'b1;
      if (lane == 0) begin last0 = '0; exp_q0.delete(); end
      else begin last1 = '0; exp_q1.delete(); end
    end else if (armed) begin
      if (done) begin
        if ((lane == 0 && exp_q0.size() == 0) || (lane == 1 && exp_q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done_lane%0d: got frame %h, required no frame", lane, got);
        end else begin
          if (lane == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
          chk($sformatf("frame_lane%0d", lane), got, e);
          if (lane == 0) last0 = e; else last1 = e;
        end
      end else begin
        chk($sformatf("hold_lane%0d", lane), got, last);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge i_clock);
      check_lane(0, done0, busy0, {1'b0, data0}, ferr0, perr0);
      check_lane(1, done1, busy1, data1, ferr1, perr1);
      @(posedge i_clock);
      rst_d = i_reset;
      #1;
    end
  endtask

  // Driver tasks
  task automatic drive(input int lane, input logic v, input int n);
    if (lane == 0) rx0 = v; else rx1 = v;
    cyc(n);
  endtask

  function automatic logic good_par(input logic [8:0] d);
    return logic'(($countones(d) + int'(parity_odd)) % 2);
  endfunction

  task automatic send_frame(input int lane, input logic [8:0] data, input int nbits,
                            input int nstop, input logic [1:0] stop_v, input logic par_v);
    int per;
    logic [10:0] e;
    per     = SB_TICK * tick_div;
    e[8:0]  = data;
    e[9]    = !stop_v[0] || (nstop == 2 && !stop_v[1]);
    e[10]   = PAR_EN && ((($countones(data) + int'(par_v)) % 2) != int'(parity_odd));
    if (lane == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    drive(lane, 1'b0, per);
    for (int i = 0; i < nbits; i++) drive(lane, data[i], per);
    if (PAR_EN) drive(lane, par_v, per);
    // A low stop bit is released early so the re-entered START sees a false start.
    for (int s = 0; s < nstop; s++) begin
      if (stop_v[s]) drive(lane, 1'b1, per);
      else begin
        drive(lane, 1'b0, per * 3 / 4);
        drive(lane, 1'b1, per / 4);
      end
    end
  endtask

  initial begin
    int per;
    logic [8:0] d;
    logic [1:0] sv;
    cyc(3);
    i_reset = 1'b0;
    cyc(20);
    per = SB_TICK * tick_div;

    send_frame(0, 9'h0A5, 8, 1, 2'b11, good_par(9'h0A5));
    cyc(2 * per);
    chk("t1_data", data0, 32'hA5);
    chk("t1_frame_err", ferr0, 32'd0);
    chk("t1_busy", busy0, 32'd0);

    rx0 = 1'b0;
    cyc(3 * tick_div);
    rx0 = 1'b1;
    cyc(2 * per);
    chk("t2_busy", busy0, 32'd0);
    chk("t2_data", data0, 32'hA5);

    send_frame(0, 9'h03C, 8, 1, 2'b10, good_par(9'h03C));
    cyc(2 * per);
    chk("t3_data", data0, 32'h3C);
    chk("t3_frame_err", ferr0, 32'd1);
    send_frame(0, 9'h055, 8, 1, 2'b11, good_par(9'h055));
    cyc(2 * per);
    chk("t3_data_ok", data0, 32'h55);
    chk("t3_frame_ok", ferr0, 32'd0);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(0, 9'h007, 8, 1, 2'b11, 1'b1);
    cyc(2 * per);
    chk("t4_parity_good", perr0, 32'd0);
    send_frame(0, 9'h007, 8, 1, 2'b11, 1'b0);
    cyc(2 * per);
    chk("t4_parity_bad", perr0, 32'd1);
`endif

    send_frame(1, 9'h1FF, 9, 2, 2'b11, good_par(9'h1FF));
    send_frame(1, 9'h1FF, 9, 2, 2'b01, good_par(9'h1FF));
    cyc(2 * per);
    chk("t5_data", data1, 32'h1FF);
    chk("t5_frame_err", ferr1, 32'd1);

    // Reset in the middle of data bit 4 of 0xFF; the rest of that frame idles high.
    drive(0, 1'b0, per);
    drive(0, 1'b1, 4 * per + per / 2);
    i_reset = 1'b1;
    cyc(1);
    i_reset = 1'b0;
    cyc(6 * per);
    chk("t6_data_after_reset", data0, 32'd0);
    chk("t6_busy_after_reset", busy0, 32'd0);
    send_frame(0, 9'h081, 8, 1, 2'b11, good_par(9'h081));
    cyc(2 * per);
    chk("t6_data", data0, 32'h81);

    // Randomised frames, both strobe rates, both lanes.
    for (int k = 0; k < 22; k++) begin
      tick_div   = ($urandom_range(0, 1) == 0) ? 1 : 4;
      per        = SB_TICK * tick_div;
      parity_odd = 1'($urandom_range(0, 1));
      cyc(2 * per);
      sv = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      if (k < 16) begin
        d = 9'($urandom_range(0, 255));
        send_frame(0, d, 8, 1, {1'b1, sv[0]}, 1'($urandom_range(0, 1)));
      end else begin
        d = 9'($urandom_range(0, 511));
        send_frame(1, d, 9, 2, sv, 1'($urandom_range(0, 1)));
      end
    end
    cyc(4 * per);
    chk("pending_lane0", exp_q0.size(), 32'd0);
    chk("pending_lane1", exp_q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
